// File: rtl/ms_fifo_pkg.sv
// Shared definitions for the multi-stream tagged FIFO slice.
// Provides width helpers (tag, pointer, count) and the tagged word layout
// {tag, data} used by both the input demux FIFO and the output-side merger.
package ms_fifo_pkg;

  // Tag width for a given flow count; never narrower than one bit.
  function automatic int unsigned tag_w(input int unsigned flux);
    return (flux <= 2) ? 1 : $clog2(flux);
  endfunction

  // Read/write pointer width for a power-of-2 depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_FLUX   = 2;
  localparam int unsigned DEF_TAG_W  = tag_w(DEF_FLUX);

  // Tagged word for the default configuration: tag in the MSBs, data in the LSBs.
  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] data;
  } tagged_word_t;

endpackage

// File: rtl/ms_fifo_lane.sv
// Single-flow first-word-fall-through circular buffer.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_en          write request for this lane (accepted only when not full)
//   wr_data        payload to store
//   rd_en          pop request (ignored when empty)
//   rd_data        registered head of the buffer, 0 while empty
//   empty, full    registered occupancy flags
//   wr_drop_c      combinational: write requested while full
module ms_fifo_lane
  import ms_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              wr_drop_c
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_acc_c, rd_acc_c;

  // Full is judged on the current state, so a same-cycle pop never rescues a write.
  assign wr_acc_c  = wr_en & ~full_q;
  assign rd_acc_c  = rd_en & ~empty_q;
  assign wr_drop_c = wr_en & full_q;

  // Next pointers, occupancy and the head word visible after this edge.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = '0;
    if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc_c) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);
    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));
    // The new head is the word being written this edge when it lands on the
    // slot the read pointer moves to; otherwise it already sits in memory.
    if (!empty_d) begin
      if (wr_acc_c && (rd_ptr_d == wr_ptr_q)) rd_data_d = wr_data;
      else                                    rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: rtl/ms_tagged_fifo.sv
// Multi-stream tagged write receiver: demultiplexes a shared {tag, data}
// write port into FLUX independent FWFT buffers.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   din        {tag, data} write word
//   write      write strobe
//   full       per-flow full flags
//   dout       per-flow head data, flow f at [f*DATA_W +: DATA_W]
//   empty      per-flow empty flags
//   read       per-flow pop strobes
//   err_drop   one-cycle pulse after a discarded write
module ms_tagged_fifo
  import ms_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FLUX   = 2,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = tag_w(FLUX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W+TAG_W-1:0]  din,
  input  logic                     write,
  output logic [FLUX-1:0]          full,
  output logic [FLUX*DATA_W-1:0]   dout,
  output logic [FLUX-1:0]          empty,
  input  logic [FLUX-1:0]          read,
  output logic                     err_drop
);

  logic [TAG_W-1:0]  tag_c;
  logic [DATA_W-1:0] data_c;
  logic [FLUX-1:0]   lane_wr_c;
  logic [FLUX-1:0]   lane_drop_c;
  logic              err_drop_q, err_drop_d;

  assign tag_c  = din[DATA_W +: TAG_W];
  assign data_c = din[DATA_W-1:0];

  for (genvar f = 0; f < FLUX; f++) begin : g_lane
    // Tag decode: a tag outside 0..FLUX-1 selects no lane.
    assign lane_wr_c[f] = write && (tag_c == TAG_W'(f));

    ms_fifo_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (lane_wr_c[f]),
      .wr_data   (data_c),
      .rd_en     (read[f]),
      .rd_data   (dout[f*DATA_W +: DATA_W]),
      .empty     (empty[f]),
      .full      (full[f]),
      .wr_drop_c (lane_drop_c[f])
    );
  end

  // Drop when the addressed lane is full or the tag hits no lane.
  assign err_drop_d = write & (~(|lane_wr_c) | (|lane_drop_c));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_drop_q <= 1'b0;
    else     err_drop_q <= err_drop_d;
  end

  assign err_drop = err_drop_q;

endmodule

// File: doc/ms_tagged_fifo.md
Name: ms_tagged_fifo

Overview:
- Receiving end of the multi-stream tagged write interface. Upstream writers drive a single shared write port: din is {tag, data}, with one write strobe and a per-flow full vector.
- The block demultiplexes each write by its tag into one of FLUX independent circular buffers. Each buffer exposes a first-word-fall-through read port to its flow's consumer actor.
- It sits at the input boundary of top_ms-style multi-flow accelerators, one instance per input stream (e.g. in_port, v_alpha, h_alpha, ext_size).

Parameters:
- DATA_W, 8: payload width in bits.
- FLUX, 2: number of flows; must be >= 2.
- DEPTH, 16: entries per flow buffer; must be a power of 2 and >= 2.
- TAG_W, $clog2(FLUX): tag width; the tag is the MSB field of din.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_W+TAG_W  {tag[TAG_W-1:0], data[DATA_W-1:0]}.
- write  in  1  write strobe, sampled on rising clk.
- full  out  FLUX  full[f] is high when flow f's buffer holds DEPTH entries.
- dout  out  FLUX*DATA_W  head data of flow f at bits [f*DATA_W +: DATA_W].
- empty  out  FLUX  empty[f] is high when flow f's buffer holds 0 entries.
- read  in  FLUX  read[f] pops flow f's head on the rising edge.
- err_drop  out  1  one-cycle pulse when a write is discarded.

Behaviour:
- Reset (async assert, sync-style deassert by design): all pointers and counts go to 0. Outputs go to empty = all 1, full = all 0, dout = 0, err_drop = 0. Memory contents are not reset.
- Write accept: the write is accepted on a rising edge when write=1, tag < FLUX and full[tag]=0. data is stored at wr_ptr[tag], and wr_ptr[tag] increments modulo DEPTH.
- Write drop: if write=1 and either full[tag]=1 or tag >= FLUX, the data is discarded. No state changes, and err_drop pulses high in the following cycle.
- full is evaluated before same-cycle reads. A write to a full flow is dropped even if read[tag]=1 in the same cycle.
- Read pop: occurs on a rising edge when read[f]=1 and empty[f]=0. rd_ptr[f] increments modulo DEPTH. read[f] while empty[f]=1 is ignored, with no underflow.
- First-word-fall-through:
  - dout[f] = mem_f[rd_ptr[f]] while empty[f]=0, and 0 while empty[f]=1.
  - Write-to-visible latency is 1 cycle: a write accepted at edge k clears empty at edge k, so dout is valid in cycle k+1.
- Simultaneous write and read on the same non-full, non-empty flow: both occur and the count is unchanged.
- Write on an empty flow with read high: the read is ignored and the write is accepted.
- Flows are fully independent. Only one flow is written per cycle, but any subset of flows may be read in the same cycle.
- count[f] is $clog2(DEPTH)+1 bits.
  - full[f] = (count==DEPTH).
  - empty[f] = (count==0).
  - full and empty are registered, derived from the next count.
- Pointer wrap is natural (DEPTH is a power of 2), so there is no special wrap handling.
- Reset mid-operation: everything returns to reset values immediately, and in-flight data is lost.

Decomposition:
- Package ms_fifo_pkg holds:
  - the function tag_w(flux) = max(1, $clog2(flux));
  - localparam-friendly helpers for the count width;
  - a typedef for the tagged word layout (tag MSB, data LSB), shared with the output-side tagged merger.
- Sub-module ms_fifo_lane is one single-flow FWFT circular buffer with ports wr_en, wr_data, rd_en, rd_data, empty, full. The top generates FLUX instances, decodes the tag into the per-lane wr_en, and ORs lane drop conditions into err_drop.

Test Plan (DATA_W=8, FLUX=2, DEPTH=16):
1. Reset, then idle: empty=2'b11, full=2'b00, dout=0, err_drop=0. Asserting rst mid-traffic restores the same values asynchronously.
2. Single-flow FWFT: write din=9'h0A5, then read[0] the next cycle. dout[7:0]=8'hA5 one cycle after the write, and empty[0] returns to 1 after the pop. Flow 1 stays untouched.
3. Interleaved flows: alternate tag 0 and tag 1 writes of 8'h00..8'h0F and 8'h80..8'h8F. Each flow must read back its own sequence in order, with no cross-flow mixing.
4. Fill and overflow: 16 writes to flow 1 raise full[1] after the 16th. A 17th write with din=9'h1FF is dropped, err_drop pulses for 1 cycle, and readback yields the original 16 values only.
5. Wrap-around with concurrency: on flow 0, hold 8 entries, then run 40 cycles of simultaneous write+read. The count stays 8, data order is preserved across pointer wrap, and full and empty stay 0.
6. Underflow and edge cases:
   - read[0] while empty: no change.
   - Write to empty flow 0 with read[0]=1: the entry is retained, and dout=data the next cycle.
   - Write to full flow 0 with read[0]=1: the write is dropped and the pop succeeds, leaving count 15.
